mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the CPU instruction-fetch requester and the load/store (data) requester.
- Arbitrates between the two requesters and latches the winning request onto the memory interface.
- Sequences exactly one outstanding transaction at a time and routes the completion back to its owner.
- Sits between instruction_fetch / data-path load-store logic and the unified memory model.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch is pending; range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted (1-cycle pulse).
- if_rvalid  out  1  fetch data valid (1-cycle pulse).
- if_rdata  out  DATA_WIDTH  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_be  in  DATA_WIDTH/8  byte enables.
- d_gnt  out  1  data request accepted (1-cycle pulse).
- d_rvalid  out  1  data completion (1-cycle pulse; reads and writes).
- d_rdata  out  DATA_WIDTH  data read data.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_be  out  DATA_WIDTH/8  memory byte enables.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_ack=1.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: every output is 0, including rdata registers; FSM = IDLE; streak counter = 0.
- All outputs are registered.
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE, no request: stays IDLE.
- IDLE, request present, arbitration and latching at the next edge:
  - Winner's addr / we / wdata / be are latched onto the mem_* outputs.
  - mem_req goes to 1.
  - Winner's gnt goes to 1 for exactly one cycle.
  - FSM moves to BUSY_IF or BUSY_D.
  - Fetch always drives mem_we=0 and mem_be=all-ones.
  - mem_wdata for a fetch keeps its previous value.
- Arbitration rule:
  - Data wins by default.
  - Fetch wins if only if_req is high, or if both are high and streak == MAX_DATA_BURST.
- Streak counter:
  - Data grant while if_req=1: streak+1, saturating at MAX_DATA_BURST.
  - Data grant while if_req=0: streak=0.
  - Fetch grant: streak=0.
- BUSY_x:
  - mem_req and all mem_* outputs are held stable until mem_ack is sampled 1.
  - On that edge: FSM returns to IDLE, mem_req goes to 0, owner's rvalid pulses for one cycle.
  - For reads, owner's rdata takes mem_rdata.
  - For data writes, d_rvalid still pulses and d_rdata keeps its previous value.
  - rdata registers hold their value until the next completion.
- Requester protocol:
  - Requester holds req/addr/wdata stable until it sees gnt.
  - Requests are not sampled in BUSY states.
  - A req still high when the FSM returns to IDLE is a new request.
- Timing:
  - Latency from req (in IDLE) to gnt / mem_req: 1 cycle.
  - Latency from mem_ack to rvalid: 1 cycle.
  - One IDLE cycle always separates transactions.
  - Peak throughput: one transaction per (memory latency + 2) cycles.
- mem_ack while IDLE: ignored, no output change.
- Simultaneous completion and request: mem_ack and a request on the same cycle is not arbitrated until the following IDLE cycle.
- Reset mid-transaction:
  - At the next edge all outputs clear and FSM = IDLE.
  - The in-flight transaction is abandoned; no rvalid is generated for it.
  - A later mem_ack is ignored.
- Requester dropping req before gnt: allowed only while the FSM is IDLE; has no effect because arbitration is per-cycle.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, mem_ack 3 cycles after mem_req with mem_rdata=0x00500093.
  - Required: if_gnt one cycle after req; mem_addr=0x100, mem_we=0; if_rvalid one cycle after ack with if_rdata=0x00500093; d_rvalid stays 0.
- Simultaneous requests: if_req and d_req together (d_addr=0x2000, read), memory answers in 1 cycle.
  - Required: d_gnt first; if_gnt on the next IDLE; completion order is data, then fetch.
- Starvation guard: MAX_DATA_BURST=4, d_req and if_req held continuously, immediate acks.
  - Required: exactly 4 d_gnt pulses, then if_gnt, then streak restarts.
- Data write: d_we=1, d_addr=0x3004, d_wdata=0xDEADBEEF, d_be=4'b0011.
  - Required: mem_* carry those values stable through a 5-cycle wait; d_rvalid pulses after ack; d_rdata unchanged.
- Reset mid-transaction: reset asserted two cycles into BUSY_D, then mem_ack arrives after reset is released.
  - Required: mem_req=0, busy=0, no d_rvalid.
- Spurious ack in IDLE: mem_ack=1 with no request.
  - Required: all outputs unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports.
// Data wins by default; a streak counter bounds how long a fetch can wait.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D
  } state_t;

  localparam logic [3:0] MAXB = 4'(MAX_DATA_BURST);

  state_t     state;
  state_t     state_n;
  logic [3:0] streak;
  logic [3:0] streak_n;
  logic       pick_d;
  logic       pick_if;
  logic       done;

  // Arbitration, streak update and completion detection.
  always_comb begin
    state_n  = state;
    streak_n = streak;
    pick_d   = 1'b0;
    pick_if  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && !(if_req && streak == MAXB)) begin
          pick_d = 1'b1;
        end else if (if_req) begin
          pick_if = 1'b1;
        end
        if (pick_d) begin
          state_n = BUSY_D;
          if (!if_req) begin
            streak_n = 4'd0;
          end else if (streak != MAXB) begin
            streak_n = streak + 4'd1;
          end
        end else if (pick_if) begin
          state_n  = BUSY_IF;
          streak_n = 4'd0;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state and streak registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      streak <= 4'd0;
    end else begin
      state  <= state_n;
      streak <= streak_n;
    end
  end

  // Registered outputs: latch the winner, pulse gnt/rvalid, capture read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= pick_if;
      d_gnt     <= pick_d;
      if_rvalid <= done && (state == BUSY_IF);
      d_rvalid  <= done && (state == BUSY_D);
      busy      <= (state_n != IDLE);
      if (pick_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
      end else if (pick_if) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
        mem_be   <= '1;
      end
      if (done) begin
        mem_req <= 1'b0;
        if (state == BUSY_IF) begin
          if_rdata <= mem_rdata;
        end
        if (state == BUSY_D && !mem_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
